// File: rtl/ps2_pkg.sv
`default_nettype none
// Shared types and set-2 byte constants for the PS/2 keyboard decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    // Keyboard status/error bytes that never form part of a key event.
    function automatic logic is_filtered(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_BAT) || (b == PS2_ECHO) ||
               (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_ERR1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_kbd_decoder_sync_fifo.sv
`default_nettype none
// Show-ahead synchronous FIFO with exact occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_decoder.sv
`default_nettype none
// PS/2 set-2 scancode decoder: folds E0/F0/E1 prefixes into key events
// and queues them behind a valid/ready FIFO.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [7:0]                    rx_data_i,
    input  logic                          rx_done_i,
    input  logic                          evt_ready_i,
    output logic                          evt_valid_o,
    output logic [7:0]                    evt_code_o,
    output logic                          evt_ext_o,
    output logic                          evt_release_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    input  logic                          clear_overflow_i,
    output logic                          resync_o
);
    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_next;
    logic [2:0]      skip, skip_next;
    logic [TO_W-1:0] to_cnt, to_cnt_next;
    logic            timeout;
    logic            push_now;
    key_event_t      evt_now;
    logic            push_q;
    key_event_t      evt_q;
    key_event_t      head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

    always_comb begin
        state_next  = state;
        skip_next   = skip;
        push_now    = 1'b0;
        evt_now     = '0;
        timeout     = (state != ST_IDLE) && !rx_done_i && (to_cnt == TO_LAST);
        if (rx_done_i) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data_i == PS2_EXT) begin
                        state_next = ST_EXT;
                    end else if (rx_data_i == PS2_BRK) begin
                        state_next = ST_BRK;
                    end else if (rx_data_i == PS2_PAUSE) begin
                        state_next = ST_PAUSE;
                        skip_next  = PAUSE_TAIL;
                    end else if (!is_filtered(rx_data_i)) begin
                        push_now = 1'b1;
                        evt_now  = '{ext: 1'b0, rel: 1'b0, code: rx_data_i};
                    end
                end
                ST_EXT: begin
                    if (rx_data_i == PS2_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        state_next = ST_IDLE;
                        push_now   = !is_filtered(rx_data_i);
                        evt_now    = '{ext: 1'b1, rel: 1'b0, code: rx_data_i};
                    end
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
                    push_now   = !is_filtered(rx_data_i);
                    evt_now    = '{ext: 1'b0, rel: 1'b1, code: rx_data_i};
                end
                ST_EXT_BRK: begin
                    state_next = ST_IDLE;
                    push_now   = !is_filtered(rx_data_i);
                    evt_now    = '{ext: 1'b1, rel: 1'b1, code: rx_data_i};
                end
                ST_PAUSE: begin
                    // The Pause tail is opaque; only its length matters.
                    if (skip == 3'd1) begin
                        state_next = ST_IDLE;
                        push_now   = 1'b1;
                        evt_now    = '{ext: 1'b1, rel: 1'b0, code: PS2_PAUSE};
                    end
                    skip_next = skip - 3'd1;
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_next = ST_IDLE;
        end
        to_cnt_next = (state == ST_IDLE || rx_done_i || timeout) ? '0 : to_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            skip     <= '0;
            to_cnt   <= '0;
            push_q   <= 1'b0;
            evt_q    <= '0;
            resync_o <= 1'b0;
        end else begin
            state    <= state_next;
            skip     <= skip_next;
            to_cnt   <= to_cnt_next;
            push_q   <= push_now;
            evt_q    <= evt_now;
            resync_o <= timeout;
        end
    end

    // A full FIFO only drops when the consumer is not popping this cycle.
    assign drop = push_q & fifo_full & ~evt_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (clear_overflow_i) begin
            overflow_o <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push_q),
        .push_data_i (evt_q),
        .pop_i       (evt_ready_i),
        .head_o      (head),
        .count_o     (fifo_count_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign evt_valid_o   = ~fifo_empty;
    assign evt_code_o    = head.code;
    assign evt_ext_o     = head.ext;
    assign evt_release_o = head.rel;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_decoder.sv
`default_nettype none
// Directed self-checking bench for ps2_kbd_decoder.
module tb_ps2_kbd_decoder;
    localparam int DEPTH = 8;
    localparam int TOUT  = 16;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_done_i = 1'b0;
    logic       evt_ready_i = 1'b0;
    logic       clear_overflow_i = 1'b0;
    logic       evt_valid_o;
    logic [7:0] evt_code_o;
    logic       evt_ext_o;
    logic       evt_release_o;
    logic [3:0] fifo_count_o;
    logic       overflow_o;
    logic       resync_o;

    int checks = 0;
    int errors = 0;
    int resync_seen = 0;

    ps2_kbd_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .rx_data_i        (rx_data_i),
        .rx_done_i        (rx_done_i),
        .evt_ready_i      (evt_ready_i),
        .evt_valid_o      (evt_valid_o),
        .evt_code_o       (evt_code_o),
        .evt_ext_o        (evt_ext_o),
        .evt_release_o    (evt_release_o),
        .fifo_count_o     (fifo_count_o),
        .overflow_o       (overflow_o),
        .clear_overflow_i (clear_overflow_i),
        .resync_o         (resync_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (resync_o) resync_seen++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data_i = b;
        rx_done_i = 1'b1;
        @(negedge clk_i);
        rx_done_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_i);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] code, input logic ext, input logic rel);
        check_eq({tag, ".valid"}, 32'(evt_valid_o), 32'd1);
        check_eq({tag, ".code"}, 32'(evt_code_o), 32'(code));
        check_eq({tag, ".ext"}, 32'(evt_ext_o), 32'(ext));
        check_eq({tag, ".rel"}, 32'(evt_release_o), 32'(rel));
        evt_ready_i = 1'b1;
        @(negedge clk_i);
        evt_ready_i = 1'b0;
    endtask

    initial begin
        int base;
        idle(2);
        check_eq("rst.valid", 32'(evt_valid_o), 32'd0);
        check_eq("rst.count", 32'(fifo_count_o), 32'd0);
        check_eq("rst.ovf", 32'(overflow_o), 32'd0);
        check_eq("rst.resync", 32'(resync_o), 32'd0);
        reset_i = 1'b0;
        idle(1);

        // Two makes with consumer ready: one-cycle latency, drained at once.
        evt_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send_byte(8'h1C);
            check_eq("make.early", 32'(evt_valid_o), 32'd0);
            idle(1);
            check_eq("make.valid", 32'(evt_valid_o), 32'd1);
            check_eq("make.code", 32'(evt_code_o), 32'h1C);
            check_eq("make.flags", 32'({evt_ext_o, evt_release_o}), 32'd0);
            idle(1);
            check_eq("make.drain", 32'(fifo_count_o), 32'd0);
        end
        evt_ready_i = 1'b0;

        // Extended release.
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        idle(1);
        check_eq("extbrk.count", 32'(fifo_count_o), 32'd1);
        pop_expect("extbrk", 8'h75, 1'b1, 1'b1);
        check_eq("extbrk.empty", 32'(fifo_count_o), 32'd0);

        // Pause sequence then a normal make.
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        send_byte(8'h1C);
        idle(1);
        check_eq("pause.count", 32'(fifo_count_o), 32'd2);
        pop_expect("pause", 8'hE1, 1'b1, 1'b0);
        pop_expect("after_pause", 8'h1C, 1'b0, 1'b0);

        // Overflow: nine makes into an eight-deep FIFO.
        for (int k = 0; k < 9; k++) send_byte(8'h10 + 8'(k));
        idle(1);
        check_eq("ovf.count", 32'(fifo_count_o), 32'd8);
        check_eq("ovf.flag", 32'(overflow_o), 32'd1);
        clear_overflow_i = 1'b1;
        idle(1);
        clear_overflow_i = 1'b0;
        check_eq("ovf.clear", 32'(overflow_o), 32'd0);
        for (int k = 0; k < 8; k++) pop_expect("ovf.pop", 8'h10 + 8'(k), 1'b0, 1'b0);
        check_eq("ovf.empty", 32'(fifo_count_o), 32'd0);
        check_eq("ovf.idle_valid", 32'(evt_valid_o), 32'd0);

        // Timeout after a lone F0: resync once, next byte is a plain make.
        base = resync_seen;
        send_byte(8'hF0);
        idle(TOUT + 8);
        check_eq("tout.pulses", 32'(resync_seen - base), 32'd1);
        send_byte(8'h1C);
        idle(1);
        pop_expect("tout.make", 8'h1C, 1'b0, 1'b0);

        // Byte arriving on the timeout cycle wins.
        base = resync_seen;
        send_byte(8'hF0);
        idle(TOUT - 1);
        send_byte(8'h75);
        idle(3);
        check_eq("tout_edge.pulses", 32'(resync_seen - base), 32'd0);
        pop_expect("tout_edge", 8'h75, 1'b0, 1'b1);

        // Status bytes in IDLE produce nothing.
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hFE);
        idle(2);
        check_eq("filter.count", 32'(fifo_count_o), 32'd0);

        // Reset mid-sequence with buffered events.
        send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'hE0);
        idle(1);
        check_eq("mid.count", 32'(fifo_count_o), 32'd3);
        #2 reset_i = 1'b1;
        #1;
        check_eq("mid.valid", 32'(evt_valid_o), 32'd0);
        check_eq("mid.count0", 32'(fifo_count_o), 32'd0);
        check_eq("mid.code", 32'({evt_code_o, evt_ext_o, evt_release_o}), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        idle(1);
        send_byte(8'h29);
        idle(1);
        pop_expect("post_rst", 8'h29, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_decoder.md
Name: ps2_kbd_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver. Consumes its 8-bit byte plus one-cycle done strobe.
- Folds set-2 prefix sequences (E0 extended, F0 break, E1 Pause) into single key events.
- Filters keyboard status bytes.
- Buffers events in a small FIFO behind a valid/ready interface for the game input-control logic.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 2_500_000, max clk_i cycles between bytes of one sequence before resync (25 ms at 100 MHz).

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  asynchronous, active-high reset
- rx_data_i  input  8  received byte; valid only when rx_done_i=1
- rx_done_i  input  1  one-cycle strobe, byte available
- evt_ready_i  input  1  consumer accepts head event this cycle
- evt_valid_o  output  1  FIFO non-empty
- evt_code_o  output  8  head event scancode
- evt_ext_o  output  1  head event was E0-prefixed, or is Pause
- evt_release_o  output  1  head event is a key release (break)
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  entries held
- overflow_o  output  1  sticky: an event was dropped because the FIFO was full
- clear_overflow_i  input  1  clears overflow_o
- resync_o  output  1  one-cycle pulse when a timeout aborts a partial sequence

Behaviour:
- Reset (asynchronous, reset_i high):
  - All outputs 0, FIFO empty, FSM in IDLE, timeout counter 0.
  - Reset mid-sequence discards the partial prefix and all buffered events.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Only advances on cycles with rx_done_i=1, except on timeout.
- IDLE:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - E1 goes to PAUSE with skip counter set to 7.
  - Filtered bytes (00, AA, EE, FA, FE, FF) stay in IDLE, no event.
  - Any other byte b pushes {code=b, ext=0, rel=0}.
- EXT: F0 goes to EXT_BRK. Any other non-filtered b pushes {b,1,0} and goes to IDLE.
- BRK: non-filtered b pushes {b,0,1} and goes to IDLE.
- EXT_BRK: non-filtered b pushes {b,1,1} and goes to IDLE.
- Filtered byte in EXT, BRK or EXT_BRK: go to IDLE, no event.
- PAUSE: swallows the next 7 bytes unconditionally. On the 7th, pushes {E1,1,0} and goes to IDLE. Pause emits no release event.
- Timeout:
  - The counter runs only outside IDLE and clears on every rx_done_i.
  - On reaching TIMEOUT_CYCLES-1, the FSM goes to IDLE, no event, and resync_o pulses for one cycle.
  - If rx_done_i arrives in the same cycle, the byte wins and the timeout is ignored.
- Latency: an event pushed from a byte sampled at edge N is visible on evt_* with evt_valid_o=1 after edge N+1. This holds when the FIFO was empty.
- FIFO behaviour:
  - Show-ahead: evt_* always reflect the head entry.
  - Pop occurs when evt_valid_o & evt_ready_i. evt_ready_i is ignored when empty.
  - Push and pop in the same cycle: both occur, count unchanged. This applies when full too (the pop frees the slot).
  - Push when full with no pop: new event dropped, overflow_o set to 1, FIFO unchanged.
  - clear_overflow_i clears overflow_o. If a drop occurs in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. Count is exact, 0..FIFO_DEPTH.

Decomposition:
- ps2_pkg holds:
  - the state enum;
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_ECHO=8'hEE, PS2_RESEND=8'hFE, PS2_ERR0=8'h00, PS2_ERR1=8'hFF;
  - packed struct key_event_t {logic ext; logic rel; logic [7:0] code}.
- One sub-module, sync_fifo: parameterised width/depth, show-ahead, with count and full/empty. The decoder instantiates it with width 10.

Test Plan:
- Bytes 1C; 1C (A make twice), consumer ready -> two events {1C,0,0}, each valid one cycle after its strobe; fifo_count_o returns to 0.
- E0 F0 75 (up-arrow release) -> exactly one event {75,1,1}; no events for E0 or F0.
- E1 14 77 E1 F0 14 F0 77 -> single event {E1,1,0}; a following 1C yields {1C,0,0}.
- evt_ready_i held 0, send 9 makes with FIFO_DEPTH=8 -> count 8, 9th dropped, overflow_o=1. Then clear_overflow_i, pop all -> codes in order, overflow_o=0.
- F0, then TIMEOUT_CYCLES idle, then 1C -> resync_o pulses once, event {1C,0,0} (not release). Also AA, FA, FE in IDLE -> no events.
- Assert reset_i mid-sequence (after E0) with 3 buffered events -> all outputs 0 immediately; next byte 29 yields {29,0,0}.
